// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for a small RV32 core (ADD SUB ADDI SLLI ORI LW SW
// BEQ BGT JAL). It sequences fetch/decode/execute/memory/write-back over one
// shared single-port memory using a req/ready handshake, and drives the
// datapath strobes.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   ir                  latched instruction register from the datapath
//   mem_ready           memory accepts/completes the current request
//   alu_zero, alu_gt    ALU compare flags (rs1-rs2 == 0, signed rs1 > rs2)
//   mem_req, mem_we     memory request, write enable (SW)
//   addr_sel            memory address: 0 = PC, 1 = ALU result
//   ir_we               load IR from memory read data
//   pc_we, pc_src       PC update, 0 = PC+4, 1 = PC+imm
//   alu_src, alu_op     ALU operand B (0 rs2, 1 imm), op (ADD/SUB/SLL/OR)
//   rf_we, wb_sel       register write, source (00 ALU, 01 mem, 10 PC+4)
//   retire, instret     retire pulse and retired-instruction count
//   halted, trap_cause  in TRAP, cause (01 illegal, 10 memory timeout)

module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    input  logic             alu_zero,
    input  logic             alu_gt,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             alu_src,
    output logic [2:0]       alu_op,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic [1:0]       trap_cause
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [31:0] TO_LAST =
        (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t      state;
    state_t      next_state;
    logic [31:0] wait_cnt;
    logic [1:0]  cause_next;

    // Instruction fields
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic       unused_ir;

    assign opc       = ir[6:0];
    assign f3        = ir[14:12];
    assign f7        = ir[31:25];
    assign rd        = ir[11:7];
    assign unused_ir = ^ir[24:15];

    logic is_add, is_sub, is_addi, is_slli, is_ori;
    logic is_lw, is_sw, is_beq, is_bgt, is_jal;
    logic is_alu, is_br, legal;

    assign is_add  = (opc == 7'b0110011) && (f3 == 3'b000)
                     && (f7 == 7'b0000000);
    assign is_sub  = (opc == 7'b0110011) && (f3 == 3'b000)
                     && (f7 == 7'b0100000);
    assign is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
    assign is_slli = (opc == 7'b0010011) && (f3 == 3'b001)
                     && (f7 == 7'b0000000);
    assign is_ori  = (opc == 7'b0010011) && (f3 == 3'b110);
    assign is_lw   = (opc == 7'b0000011) && (f3 == 3'b010);
    assign is_sw   = (opc == 7'b0100011) && (f3 == 3'b010);
    assign is_beq  = (opc == 7'b1100011) && (f3 == 3'b000);
    assign is_bgt  = (opc == 7'b1100011) && (f3 == 3'b100);
    assign is_jal  = (opc == 7'b1101111);

    assign is_alu = is_add | is_sub | is_addi | is_slli | is_ori;
    assign is_br  = is_beq | is_bgt;
    assign legal  = is_alu | is_lw | is_sw | is_br | is_jal;

    // ALU control as a function of the instruction alone; the FSM decides
    // in which states it is actually driven.
    logic       dec_alu_src;
    logic [2:0] dec_alu_op;

    always_comb begin
        dec_alu_src = is_addi | is_slli | is_ori | is_lw | is_sw;
        dec_alu_op  = 3'b000;
        unique case (1'b1)
            is_sub, is_br: dec_alu_op = 3'b001;
            is_slli:       dec_alu_op = 3'b010;
            is_ori:        dec_alu_op = 3'b011;
            default:       dec_alu_op = 3'b000;
        endcase
    end

    // Last allowed wait cycle with no ready: the request gives up here.
    logic timeout_hit;
    assign timeout_hit = (TIMEOUT > 0) && !mem_ready
                         && (wait_cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            instret    <= '0;
            trap_cause <= 2'b00;
        end else begin
            state <= next_state;
            // Any state change clears the counter, so it starts at zero
            // on every entry into FETCH or MEM.
            if (next_state != state)
                wait_cnt <= '0;
            else if (!mem_ready)
                wait_cnt <= wait_cnt + 32'd1;
            if (retire)
                instret <= instret + CNT_W'(1);
            if (state != S_TRAP && next_state == S_TRAP)
                trap_cause <= cause_next;
        end
    end

    always_comb begin
        next_state = state;
        cause_next = 2'b00;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 3'b000;
        rf_we      = 1'b0;
        wb_sel     = 2'b00;
        retire     = 1'b0;
        halted     = 1'b0;
        case (state)
            S_IDLE: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                    cause_next = 2'b10;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    next_state = S_EXEC;
                end else begin
                    next_state = S_TRAP;
                    cause_next = 2'b01;
                end
            end
            S_EXEC: begin
                alu_src = dec_alu_src;
                alu_op  = dec_alu_op;
                if (is_br) begin
                    pc_we      = 1'b1;
                    pc_src     = (is_beq & alu_zero) | (is_bgt & alu_gt);
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else if (is_lw | is_sw) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_sw;
                alu_src  = dec_alu_src;
                alu_op   = dec_alu_op;
                if (mem_ready) begin
                    if (is_sw) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                    cause_next = 2'b10;
                end
            end
            S_WB: begin
                // ALU inputs stay driven so its result is stable for the
                // register write.
                alu_src    = dec_alu_src;
                alu_op     = dec_alu_op;
                rf_we      = (rd != 5'd0);
                wb_sel     = is_jal ? 2'b10 : (is_lw ? 2'b01 : 2'b00);
                pc_we      = 1'b1;
                pc_src     = is_jal;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_TRAP: begin
                halted = 1'b1;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl.
// Each cycle's strobes are packed into one vector and compared per state.

module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir;
    logic        mem_ready;
    logic        alu_zero;
    logic        alu_gt;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        retire;
    logic [31:0] instret;
    logic        halted;
    logic [1:0]  trap_cause;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ir         (ir),
        .mem_ready  (mem_ready),
        .alu_zero   (alu_zero),
        .alu_gt     (alu_gt),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addr_sel   (addr_sel),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .retire     (retire),
        .instret    (instret),
        .halted     (halted),
        .trap_cause (trap_cause)
    );

    always #5 clk = ~clk;

    // Layout: mem_req mem_we addr_sel ir_we pc_we pc_src alu_src
    //         alu_op[2:0] rf_we wb_sel[1:0] retire halted
    function automatic logic [14:0] obs();
        return {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src,
                alu_src, alu_op, rf_we, wb_sel, retire, halted};
    endfunction

    localparam logic [14:0] Z     = 15'b0_0_0_0_0_0_0_000_0_00_0_0;
    localparam logic [14:0] FETW  = 15'b1_0_0_0_0_0_0_000_0_00_0_0;
    localparam logic [14:0] FETR  = 15'b1_0_0_1_0_0_0_000_0_00_0_0;
    localparam logic [14:0] TRAPV = 15'b0_0_0_0_0_0_0_000_0_00_0_1;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LW   = 32'h0040A103;
    localparam logic [31:0] SW   = 32'h0020A423;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] BGT  = 32'h0020C463;
    localparam logic [31:0] JAL0 = 32'h0000006F;
    localparam logic [31:0] JAL1 = 32'h000000EF;

    // Leaves the DUT in IDLE for the current cycle (posedge+1).
    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        ir        = ADDI;
        mem_ready = 1'b1;
        alu_zero  = 1'b0;
        alu_gt    = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== Z) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=%b", obs(), Z);
        end
        checks++;
        if (instret !== 32'd0 || trap_cause !== 2'b00) begin
            failures++;
            $display("FAIL reset_regs got=%0d/%b exp=0/00",
                     instret, trap_cause);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_addi();
        logic [14:0] exp [6];
        bit          rdy [6];
        exp = '{Z, FETR, Z,
                15'b0_0_0_0_0_0_1_000_0_00_0_0,
                15'b0_0_0_0_1_0_1_000_1_00_1_0,
                FETR};
        rdy = '{1, 1, 1, 1, 1, 1};
        do_reset();
        ir = ADDI;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                failures++;
                $display("FAIL addi cyc%0d got=%b exp=%b",
                         i, obs(), exp[i]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (instret !== 32'd1) begin
            failures++;
            $display("FAIL addi_instret got=%0d exp=1", instret);
        end
    endtask

    task automatic test_lw_wait();
        logic [14:0] exp [10];
        bit          rdy [10];
        exp = '{Z, FETR, Z,
                15'b0_0_0_0_0_0_1_000_0_00_0_0,
                15'b1_0_1_0_0_0_1_000_0_00_0_0,
                15'b1_0_1_0_0_0_1_000_0_00_0_0,
                15'b1_0_1_0_0_0_1_000_0_00_0_0,
                15'b1_0_1_0_0_0_1_000_0_00_0_0,
                15'b0_0_0_0_1_0_1_000_1_01_1_0,
                FETR};
        rdy = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
        do_reset();
        ir = LW;
        for (int i = 0; i < 10; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                failures++;
                $display("FAIL lw_wait cyc%0d got=%b exp=%b",
                         i, obs(), exp[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch();
        logic [14:0] exp [5];
        // BEQ taken
        exp = '{Z, FETR, Z,
                15'b0_0_0_0_1_1_0_001_0_00_1_0, FETR};
        do_reset();
        ir       = BEQ;
        alu_zero = 1'b1;
        alu_gt   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                failures++;
                $display("FAIL beq cyc%0d got=%b exp=%b",
                         i, obs(), exp[i]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (instret !== 32'd1) begin
            failures++;
            $display("FAIL beq_instret got=%0d exp=1", instret);
        end
        // BGT not taken even though alu_zero is set
        exp = '{Z, FETR, Z,
                15'b0_0_0_0_1_0_0_001_0_00_1_0, FETR};
        do_reset();
        ir = BGT;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                failures++;
                $display("FAIL bgt cyc%0d got=%b exp=%b",
                         i, obs(), exp[i]);
            end
            @(posedge clk);
            #1;
        end
        alu_zero = 1'b0;
    endtask

    task automatic test_jal();
        logic [14:0] exp [6];
        exp = '{Z, FETR, Z, Z,
                15'b0_0_0_0_1_1_0_000_0_10_1_0, FETR};
        do_reset();
        ir = JAL0;
        for (int i = 0; i < 6; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                failures++;
                $display("FAIL jal_x0 cyc%0d got=%b exp=%b",
                         i, obs(), exp[i]);
            end
            @(posedge clk);
            #1;
        end
        exp = '{Z, FETR, Z, Z,
                15'b0_0_0_0_1_1_0_000_1_10_1_0, FETR};
        do_reset();
        ir = JAL1;
        for (int i = 0; i < 6; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                failures++;
                $display("FAIL jal_x1 cyc%0d got=%b exp=%b",
                         i, obs(), exp[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_illegal();
        logic [14:0] exp [6];
        exp = '{Z, FETR, Z, TRAPV, TRAPV, TRAPV};
        do_reset();
        ir = 32'hFFFFFFFF;
        for (int i = 0; i < 6; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                failures++;
                $display("FAIL illegal cyc%0d got=%b exp=%b",
                         i, obs(), exp[i]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (trap_cause !== 2'b01) begin
            failures++;
            $display("FAIL illegal_cause got=%b exp=01", trap_cause);
        end
    endtask

    task automatic test_timeout();
        logic [14:0] exp [19];
        bit          rdy [19];
        // 16 unanswered FETCH cycles, then TRAP
        for (int i = 0; i < 19; i++) begin
            rdy[i] = (i == 18);
            if (i == 0)
                exp[i] = Z;
            else if (i <= 16)
                exp[i] = FETW;
            else
                exp[i] = TRAPV;
        end
        do_reset();
        ir = ADDI;
        for (int i = 0; i < 19; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                failures++;
                $display("FAIL timeout cyc%0d got=%b exp=%b",
                         i, obs(), exp[i]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (trap_cause !== 2'b10) begin
            failures++;
            $display("FAIL timeout_cause got=%b exp=10", trap_cause);
        end
        // Ready on the 16th wait cycle still wins
        for (int i = 0; i < 18; i++) begin
            rdy[i] = (i == 0) || (i >= 16);
            if (i == 0 || i == 17)
                exp[i] = Z;
            else if (i == 16)
                exp[i] = FETR;
            else
                exp[i] = FETW;
        end
        do_reset();
        for (int i = 0; i < 18; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                failures++;
                $display("FAIL ready_wins cyc%0d got=%b exp=%b",
                         i, obs(), exp[i]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (trap_cause !== 2'b00) begin
            failures++;
            $display("FAIL ready_wins_cause got=%b exp=00", trap_cause);
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp [9];
        bit          rdy [9];
        localparam logic [14:0] SWX = 15'b0_0_0_0_0_0_1_000_0_00_0_0;
        exp = '{Z, FETR, Z, SWX,
                15'b1_1_1_0_1_0_1_000_0_00_1_0,
                FETR, Z, SWX,
                15'b1_1_1_0_0_0_1_000_0_00_0_0};
        rdy = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        do_reset();
        ir = SW;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            checks++;
            if (obs() !== exp[i]) begin
                failures++;
                $display("FAIL sw_b2b cyc%0d got=%b exp=%b",
                         i, obs(), exp[i]);
            end
            if (i < 8) begin
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (instret !== 32'd1) begin
            failures++;
            $display("FAIL sw_instret got=%0d exp=1", instret);
        end
        // Reset lands in the middle of the second SW's MEM wait
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || instret !== 32'd0) begin
            failures++;
            $display("FAIL mid_mem_reset got=%b%b/%0d exp=00/0",
                     mem_req, mem_we, instret);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== Z) begin
            failures++;
            $display("FAIL restart_idle got=%b exp=%b", obs(), Z);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (obs() !== FETR) begin
            failures++;
            $display("FAIL restart_fetch got=%b exp=%b", obs(), FETR);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lw_wait();
        test_branch();
        test_jal();
        test_illegal();
        test_timeout();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32 subset core: ADD, SUB, ADDI, SLLI, ORI, LW, SW, BEQ, BGT, JAL.
- Sequences fetch, decode, execute, memory and write-back over a shared single-port memory with a req/ready handshake.
- Drives the datapath strobes: IR load, PC update, ALU op, register-file write and write-back mux.
- Sits between the datapath (IR, immediate generator, ALU, register file) and unified memory. Traps on illegal instructions or memory timeout.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_ready per request; 0 = no timeout.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ir  in  32  latched instruction register from datapath.
- mem_ready  in  1  memory accepts/completes current request this cycle.
- alu_zero  in  1  ALU result (rs1-rs2) == 0.
- alu_gt  in  1  signed rs1 > rs2.
- mem_req  out  1  memory request.
- mem_we  out  1  write (SW) when mem_req.
- addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = PC+imm.
- alu_src  out  1  0 = rs2, 1 = imm.
- alu_op  out  3  000 ADD, 001 SUB, 010 SLL, 011 OR.
- rf_we  out  1  register-file write.
- wb_sel  out  2  00 ALU, 01 mem data, 10 PC+4.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  CNT_W  retired-instruction count.
- halted  out  1  in TRAP.
- trap_cause  out  2  00 none, 01 illegal, 10 mem timeout.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. State register, wait counter, instret, trap_cause are flops. Strobes are combinational from state, ir and inputs.
- Reset (async, any state, mid-transaction included): state = IDLE, counters = 0, trap_cause = 00. All outputs are 0 while in reset and in IDLE. Any outstanding request is abandoned.
- IDLE: next cycle goes to FETCH.
- FETCH: mem_req = 1, addr_sel = 0. On mem_ready: ir_we = 1, go to DECODE. Otherwise stay.
- DECODE: one cycle (register read / immediate settle). Legal instruction goes to EXEC. Anything else goes to TRAP with cause 01. Legal encodings:
  - opcode 0110011 with funct3 000 and funct7 0000000 (ADD) or 0100000 (SUB);
  - opcode 0010011 with funct3 000 (ADDI), 001 (SLLI, funct7 = 0), 110 (ORI);
  - LW: 0000011 with funct3 010;
  - SW: 0100011 with funct3 010;
  - branch: 1100011 with funct3 000 (BEQ) or 100 (BGT);
  - JAL: 1101111.
- EXEC: alu_src and alu_op per instruction. Loads/stores use ADD and imm; branches use SUB and rs2.
  - ALU ops go to WB.
  - LW/SW go to MEM.
  - Branch: pc_we = 1; pc_src = (BEQ & alu_zero) | (BGT & alu_gt); retire; go to FETCH.
  - JAL goes to WB.
- MEM: mem_req = 1, addr_sel = 1, mem_we = SW. Hold ALU inputs stable. On mem_ready:
  - SW: pc_we = 1, pc_src = 0, retire, go to FETCH.
  - LW: go to WB.
- WB: rf_we = 1 unless ir[11:7] == 0. wb_sel = 10 for JAL, 01 for LW, else 00. pc_we = 1, pc_src = JAL. Retire, go to FETCH.
- retire: same cycle as the final pc_we. instret increments by 1 and wraps at 2^CNT_W.
- Wait counter: cleared on entering FETCH/MEM; increments each cycle mem_ready = 0.
  - If TIMEOUT > 0 and the counter reaches TIMEOUT with mem_ready = 0: go to TRAP, cause 10, no ir_we/pc_we.
  - mem_ready on the first request cycle means zero wait.
  - mem_ready in the same cycle the count would hit TIMEOUT: ready wins.
- TRAP: all strobes 0, halted = 1, trap_cause held. Exit only via rst.
- Latency with zero-wait memory: ALU/JAL 4 cycles, LW 5, SW 4, branch 3.

Test Plan:
- Reset release, ir = ADDI x1,x0,5 (0x00500093), mem_ready = 1 -> IDLE, FETCH (ir_we), DECODE, EXEC (alu_src = 1, alu_op = 000), WB (rf_we = 1, wb_sel = 00, pc_we = 1, pc_src = 0, retire); instret = 1.
- LW x2,4(x1) with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles with mem_req = 1, addr_sel = 1, mem_we = 0; then WB with wb_sel = 01; total 8 cycles.
- BEQ with alu_zero = 1 -> EXEC pc_we = 1, pc_src = 1. BGT with alu_gt = 0 -> pc_src = 0. Neither has rf_we.
- JAL x0 -> WB with rf_we = 0 (rd = 0), pc_src = 1. JAL x1 -> rf_we = 1, wb_sel = 10.
- ir = 0xFFFFFFFF -> TRAP after DECODE, halted = 1, trap_cause = 01, then stays with all strobes 0. mem_ready held 0 for 16 FETCH cycles -> TRAP, cause 10.
- rst asserted mid-MEM of SW -> immediate mem_req = 0, mem_we = 0, instret = 0; restart at FETCH after release.
